// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
//
// Fetches one 16-pixel sprite line (8 bits per pixel) from the sprite VRAM
// and serializes it to the scanline compositor. Each accepted pixel beat
// carries its screen x coordinate.
//
// Optional feature macro: SPRITE_FLIP_EN. When it is defined, the req_flip
// port exists and a flipped line is emitted from pixel 15 down to pixel 0.
//
// Handshake rule (both req_* and pix_*): a transfer happens on a rising clk
// edge where valid && ready are both high. A producer that raises valid
// keeps valid and its payload stable until that transfer happens.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   req_valid/ready   line fetch request handshake
//   req_sprite_id     sprite index (8 bits)
//   req_row           row within the sprite (4 bits)
//   req_x             screen x of the sprite's leftmost pixel
//   req_flip          horizontal flip (only with SPRITE_FLIP_EN)
//   vram_read_addr    {sprite_id, row} line address, registered at accept
//   vram_read_data    VRAM line; only [127:0] is used
//   pix_valid/ready   pixel beat handshake
//   pix_data          pixel colour index
//   pix_opaque        pix_data != 0 (index 0 is transparent)
//   pix_x             screen x of this pixel, wraps modulo 2^X_WIDTH
//   pix_last          16th pixel of the line
//   busy              FSM is not IDLE
//   state_dbg         current FSM state (0 IDLE, 1 ADDR, 2 CAPTURE, 3 SHIFT)
module sprite_line_fetcher #(
  parameter int X_WIDTH = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         req_sprite_id,
  input  logic [3:0]         req_row,
  input  logic [X_WIDTH-1:0] req_x,
`ifdef SPRITE_FLIP_EN
  input  logic               req_flip,
`endif
  output logic [11:0]        vram_read_addr,
  input  logic [255:0]       vram_read_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [7:0]         pix_data,
  output logic               pix_opaque,
  output logic [X_WIDTH-1:0] pix_x,
  output logic               pix_last,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CAPTURE = 2'd2,
    SHIFT   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [127:0]         line_q;
  logic [3:0]           cnt;
  logic [X_WIDTH-1:0]   x_q;
  logic [3:0]           pix_idx;
  logic [7:0]           cur_pix;
  logic                 accept;
  logic                 beat;

  // The upper half of the VRAM word carries nothing for this block.
  logic unused_upper;
  assign unused_upper = ^vram_read_data[255:128];

  assign accept = (state == IDLE) && req_valid;
  assign beat   = (state == SHIFT) && pix_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_read_addr <= '0;
      x_q            <= '0;
      line_q         <= '0;
      cnt            <= '0;
    end else begin
      if (accept) begin
        vram_read_addr <= {req_sprite_id, req_row};
        x_q            <= req_x;
      end
      if (state == CAPTURE) begin
        line_q <= vram_read_data[127:0];
        cnt    <= '0;
      end else if (beat) begin
        // Wraps 15 -> 0 on the last beat; CAPTURE clears it again anyway.
        cnt <= cnt + 4'd1;
      end
    end
  end

`ifdef SPRITE_FLIP_EN
  logic flip_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flip_q <= 1'b0;
    end else if (accept) begin
      flip_q <= req_flip;
    end
  end

  // 15-cnt is the bitwise inverse of a 4-bit counter.
  assign pix_idx = flip_q ? ~cnt : cnt;
`else
  assign pix_idx = cnt;
`endif

  assign cur_pix = line_q[{pix_idx, 3'b000} +: 8];

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = ADDR;
      ADDR:    state_n = CAPTURE;
      CAPTURE: state_n = SHIFT;
      SHIFT:   if (pix_ready && (cnt == 4'd15)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs. Pixel outputs are forced to zero outside SHIFT so they
  // match their reset values whenever no beat is offered.
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    pix_opaque = 1'b0;
    pix_x      = '0;
    pix_last   = 1'b0;
    state_dbg  = state;
    case (state)
      IDLE: begin
        // Requests offered while reset is held are not accepted.
        req_ready = !reset;
      end
      ADDR, CAPTURE: begin
        busy = 1'b1;
      end
      SHIFT: begin
        busy       = 1'b1;
        pix_valid  = 1'b1;
        pix_data   = cur_pix;
        pix_opaque = (cur_pix != 8'h00);
        pix_x      = x_q + X_WIDTH'(cnt);
        pix_last   = (cnt == 4'd15);
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;

  localparam int XW = 9;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [7:0]    req_sprite_id;
  logic [3:0]    req_row;
  logic [XW-1:0] req_x;
  logic          req_flip;
  logic [11:0]   vram_read_addr;
  logic [255:0]  vram_read_data;
  logic          pix_valid;
  logic          pix_ready;
  logic [7:0]    pix_data;
  logic          pix_opaque;
  logic [XW-1:0] pix_x;
  logic          pix_last;
  logic          busy;
  logic [1:0]    state_dbg;

  sprite_line_fetcher #(.X_WIDTH(XW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_sprite_id  (req_sprite_id),
    .req_row        (req_row),
    .req_x          (req_x),
`ifdef SPRITE_FLIP_EN
    .req_flip       (req_flip),
`endif
    .vram_read_addr (vram_read_addr),
    .vram_read_data (vram_read_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_data       (pix_data),
    .pix_opaque     (pix_opaque),
    .pix_x          (pix_x),
    .pix_last       (pix_last),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- VRAM model: one-cycle synchronous read ----------------
  logic [127:0] mem [0:4095];

  always @(posedge clk) begin
    // Upper half filled with noise; the DUT must ignore it.
    vram_read_data <= {$urandom(), $urandom(), $urandom(), $urandom(), mem[vram_read_addr]};
  end

  // ---------------- pix_ready driver ----------------
  int ready_mode = 0;  // 0 always ready, 1 pattern 1,0,0, 2 random
  int ready_ph   = 0;

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_ph++;
      case (ready_mode)
        1:       pix_ready = ((ready_ph % 3) == 0);
        2:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  // entry: {last, opaque, x[8:0], data[7:0]}
  logic [18:0] exp_q[$];
  int          neg_cnt      = 0;
  int          accept_neg   = 0;
  int          last_neg     = -100;
  int          accept_gap   = 0;
  int          n_accepts    = 0;
  int          beats        = 0;
  logic        first_pend   = 1'b0;
  logic        addr_pend    = 1'b0;
  logic [11:0] addr_exp     = '0;

  task automatic push_line(input logic [7:0] id, input logic [3:0] row,
                           input logic [XW-1:0] x, input logic flip);
    logic [127:0]  ln;
    logic [7:0]    d;
    logic [XW-1:0] xx;
    int            k;
    ln = mem[{id, row}];
    for (int n = 0; n < 16; n++) begin
      k  = flip ? (15 - n) : n;
      d  = ln[8*k +: 8];
      xx = x + XW'(n);
      exp_q.push_back({(n == 15), (d != 8'h00), xx, d});
    end
  endtask

  initial begin
    logic [18:0] e;
    logic        f;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (!reset) begin
        if (addr_pend) begin
          check("vram_read_addr", 32'(vram_read_addr), 32'(addr_exp));
          addr_pend = 1'b0;
        end
        if (pix_valid) begin
          if (first_pend) begin
            check("first_valid_latency", 32'(neg_cnt - accept_neg), 32'd3);
            first_pend = 1'b0;
          end
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(pix_valid), 32'd0);
          end else begin
            e = exp_q[0];
            check("pix_data",   32'(pix_data),   32'(e[7:0]));
            check("pix_x",      32'(pix_x),      32'(e[16:8]));
            check("pix_opaque", 32'(pix_opaque), 32'(e[17]));
            check("pix_last",   32'(pix_last),   32'(e[18]));
            if (pix_ready) begin
              void'(exp_q.pop_front());
              beats++;
              if (e[18]) begin
                check("beat_count", 32'(beats), 32'd16);
                beats    = 0;
                last_neg = neg_cnt;
              end
            end
          end
        end
        if (req_valid && req_ready) begin
`ifdef SPRITE_FLIP_EN
          f = req_flip;
`else
          f = 1'b0;
`endif
          push_line(req_sprite_id, req_row, req_x, f);
          addr_exp   = {req_sprite_id, req_row};
          addr_pend  = 1'b1;
          first_pend = 1'b1;
          accept_neg = neg_cnt;
          accept_gap = neg_cnt - last_neg;
          n_accepts++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble_req();
    req_sprite_id = 8'($urandom());
    req_row       = 4'($urandom());
    req_x         = XW'($urandom());
    req_flip      = 1'($urandom());
  endtask

  task automatic request(input logic [7:0] id, input logic [3:0] row,
                         input logic [XW-1:0] x, input logic flip);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_sprite_id = id;
    req_row       = row;
    req_x         = x;
    req_flip      = flip;
    req_valid     = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Later field changes must not affect the line in flight.
    scramble_req();
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("line_done_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_inc(input logic [11:0] a);
    logic [127:0] ln;
    for (int n = 0; n < 16; n++) ln[8*n +: 8] = 8'(n + 1);
    mem[a] = ln;
  endtask

  task automatic load_alt(input logic [11:0] a);
    logic [127:0] ln;
    for (int n = 0; n < 16; n++) ln[8*n +: 8] = (n % 2 == 0) ? 8'h00 : 8'hFF;
    mem[a] = ln;
  endtask

  task automatic load_rand(input logic [11:0] a);
    logic [127:0] ln;
    for (int n = 0; n < 16; n++) ln[8*n +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
    mem[a] = ln;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    logic flip_b;
    bit   ok;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_sprite_id = '0;
    req_row       = '0;
    req_x         = '0;
    req_flip      = 1'b0;

    // Reset values, with a request offered during reset.
    repeat (2) @(posedge clk);
    #1;
    req_valid     = 1'b1;
    req_sprite_id = 8'h03;
    req_row       = 4'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready),      32'd0);
    check("rst_vram_addr",  32'(vram_read_addr), 32'd0);
    check("rst_pix_valid",  32'(pix_valid),      32'd0);
    check("rst_pix_data",   32'(pix_data),       32'd0);
    check("rst_pix_opaque", 32'(pix_opaque),     32'd0);
    check("rst_pix_x",      32'(pix_x),          32'd0);
    check("rst_pix_last",   32'(pix_last),       32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_state",      32'(state_dbg),      32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy",      32'(busy),      32'd0);

    // Basic line, always ready.
    load_inc(12'h035);
    request(8'h03, 4'h5, 9'd100, 1'b0);
    wait_idle(100);

    // Same line under 1,0,0 backpressure.
    ready_mode = 1;
    ready_ph   = 0;
    request(8'h03, 4'h5, 9'd100, 1'b0);
    wait_idle(200);
    ready_mode = 0;

    // Transparent / opaque alternation.
    load_alt(12'h127);
    request(8'h12, 4'h7, 9'd40, 1'b0);
    wait_idle(100);

    // Screen x wrap.
    request(8'h03, 4'h5, 9'd510, 1'b0);
    wait_idle(100);

    // Random lines under random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      logic [7:0]    rid;
      logic [3:0]    rrow;
      logic [XW-1:0] rx;
      rid  = 8'($urandom_range(0, 255));
      rrow = 4'($urandom_range(0, 15));
      rx   = XW'($urandom_range(0, 511));
      load_rand({rid, rrow});
`ifdef SPRITE_FLIP_EN
      request(rid, rrow, rx, 1'($urandom_range(0, 1)));
`else
      request(rid, rrow, rx, 1'b0);
`endif
      wait_idle(400);
    end
    ready_mode = 0;

    // Reset after the 5th beat.
    request(8'h03, 4'h5, 9'd20, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (beats == 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("fifth_beat_timeout", 32'(beats), 32'd5);
    // The 5th beat is sampled; its handshake edge is the next posedge.
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    check("midrst_pix_valid", 32'(pix_valid), 32'd0);
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    beats      = 0;
    first_pend = 1'b0;
    addr_pend  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #2;
    check("midrst_after_req_ready", 32'(req_ready), 32'd1);
    check("midrst_after_pix_valid", 32'(pix_valid), 32'd0);
    load_rand(12'h9A3);
    request(8'h9A, 4'h3, 9'd300, 1'b0);
    wait_idle(100);

    // Back-to-back with req_valid held high.
`ifdef SPRITE_FLIP_EN
    flip_b = 1'b1;
`else
    flip_b = 1'b0;
`endif
    @(posedge clk);
    #1;
    req_sprite_id = 8'h03;
    req_row       = 4'h5;
    req_x         = 9'd50;
    req_flip      = 1'b0;
    req_valid     = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("b2b_first_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_sprite_id = 8'h12;
    req_row       = 4'h7;
    req_x         = 9'd200;
    req_flip      = flip_b;
    begin
      int target;
      target = n_accepts + 1;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        #2;
        if (n_accepts == target) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check("b2b_second_timeout", 32'(n_accepts), 32'(target));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_req();
    check("b2b_accept_gap", 32'(accept_gap), 32'd1);
    wait_idle(100);

`ifdef SPRITE_FLIP_EN
    // Flipped line: data 16..1, x ascending.
    request(8'h03, 4'h5, 9'd30, 1'b1);
    wait_idle(100);
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle",        32'(busy),         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
